fpnew_opgroup_share_arb: RTL and testbench

- Shares one opgroup block between NumReq independent requesters, e.g. several harts or lanes on one DIVSQRT unit.
- Round-robin arbitrates incoming operations and tags each issued operation with its requester index.
- Routes results back to the requester by tag.
- Enforces a per-requester outstanding-operation credit limit.
- Sits between the requesters' issue stages and the opgroup block's input/output handshakes.

---
 rtl/fpnew_pkg.sv | 36 +++
 rtl/fpnew_credit_counter.sv | 35 +++
 rtl/fpnew_opgroup_share_arb.sv | 147 ++++++++++++++
 tb/tb_fpnew_opgroup_share_arb.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPnew types used by the opgroup sharing arbiter.
// Operation, format, rounding mode and status encodings.
package fpnew_pkg;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpnew_credit_counter.sv
// Per-requester in-flight counter: up on issue, down on response.
// Flush and reset both clear it; a same-cycle up and down cancel.
module fpnew_credit_counter #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [CntWidth-1:0] cnt_q;

  assign full_o  = (cnt_q == CntWidth'(MaxOutstanding));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_q <= cnt_q - CntWidth'(1);
    end
  end

endmodule

// File: rtl/fpnew_opgroup_share_arb.sv
// Shares one opgroup block between NumReq requesters: round-robin
// issue with a hold lock, tag-routed results and per-requester credits.
module fpnew_opgroup_share_arb
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned Width          = 32,
  parameter int unsigned NumOperands    = 3,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxWidth      = $clog2(NumReq)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  input  logic [NumReq-1:0]                         req_valid_i,
  output logic [NumReq-1:0]                         req_ready_o,
  input  logic [NumReq-1:0][NumOperands-1:0][Width-1:0] req_operands_i,
  input  operation_e [NumReq-1:0]                   req_op_i,
  input  logic [NumReq-1:0]                         req_op_mod_i,
  input  fp_format_e [NumReq-1:0]                   req_fmt_i,
  input  roundmode_e [NumReq-1:0]                   req_rnd_mode_i,
  output logic                                      unit_valid_o,
  input  logic                                      unit_ready_i,
  output logic [NumOperands-1:0][Width-1:0]         unit_operands_o,
  output operation_e                                unit_op_o,
  output logic                                      unit_op_mod_o,
  output fp_format_e                                unit_fmt_o,
  output roundmode_e                                unit_rnd_mode_o,
  output logic [IdxWidth-1:0]                       unit_tag_o,
  output logic                                      unit_flush_o,
  input  logic                                      unit_out_valid_i,
  output logic                                      unit_out_ready_o,
  input  logic [Width-1:0]                          unit_result_i,
  input  status_t                                   unit_status_i,
  input  logic [IdxWidth-1:0]                       unit_tag_i,
  output logic [NumReq-1:0]                         rsp_valid_o,
  input  logic [NumReq-1:0]                         rsp_ready_i,
  output logic [Width-1:0]                          rsp_result_o,
  output status_t                                   rsp_status_o,
  output logic                                      err_o,
  output logic                                      busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic [NumReq-1:0]   full, empty, inc, dec, eligible;
  logic [NumReq-1:0]   tag_sel;
  logic [CntWidth-1:0] cnt [NumReq];
  logic [IdxWidth-1:0] rr_ptr, lock_idx, grant_idx, next_ptr;
  logic                lock, grant_vld, issue_hs;
  logic                tag_live, tag_rdy, rsp_bad, err_q;

  assign eligible = req_valid_i & ~full;

  // Search starts at rr_ptr; descending loop so the nearest index wins.
  always_comb begin
    int unsigned j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (lock) begin
      grant_vld = 1'b1;
      grant_idx = lock_idx;
    end else begin
      for (int unsigned k = NumReq; k > 0; k--) begin
        j = (32'(rr_ptr) + k - 1) % NumReq;
        if (eligible[IdxWidth'(j)]) begin
          grant_vld = 1'b1;
          grant_idx = IdxWidth'(j);
        end
      end
    end
  end

  assign unit_valid_o    = grant_vld & ~flush_i & ~rst_i;
  assign issue_hs        = unit_valid_o & unit_ready_i;
  assign unit_operands_o = req_operands_i[grant_idx];
  assign unit_op_o       = req_op_i[grant_idx];
  assign unit_op_mod_o   = req_op_mod_i[grant_idx];
  assign unit_fmt_o      = req_fmt_i[grant_idx];
  assign unit_rnd_mode_o = req_rnd_mode_i[grant_idx];
  assign unit_tag_o      = grant_idx;
  assign unit_flush_o    = flush_i;

  always_comb begin
    req_ready_o            = '0;
    req_ready_o[grant_idx] = issue_hs;
  end

  assign next_ptr = (grant_idx == IdxWidth'(NumReq - 1)) ?
                    '0 : grant_idx + IdxWidth'(1);

  assign tag_live = |(tag_sel & ~empty);
  assign tag_rdy  = |(tag_sel & rsp_ready_i);
  assign rsp_bad  = unit_out_valid_i & ~tag_live;

  // A result with an unknown or idle tag is swallowed and flagged.
  assign unit_out_ready_o = ~rst_i & (rsp_bad | tag_rdy);
  assign rsp_result_o     = unit_result_i;
  assign rsp_status_o     = unit_status_i;

  for (genvar i = 0; i < NumReq; i++) begin : g_req
    assign tag_sel[i] = (unit_tag_i == IdxWidth'(i));
    assign rsp_valid_o[i] = ~rst_i & unit_out_valid_i &
                            ~rsp_bad & tag_sel[i];
    assign dec[i] = rsp_valid_o[i] & rsp_ready_i[i];
    assign inc[i] = issue_hs & (grant_idx == IdxWidth'(i));

    fpnew_credit_counter #(
      .MaxOutstanding (MaxOutstanding),
      .CntWidth       (CntWidth)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .inc_i   (inc[i]),
      .dec_i   (dec[i]),
      .cnt_o   (cnt[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      if (rsp_bad) err_q <= 1'b1;
      if (flush_i) begin
        lock <= 1'b0;
      end else if (issue_hs) begin
        lock   <= 1'b0;
        rr_ptr <= next_ptr;
      end else if (unit_valid_o) begin
        lock     <= 1'b1;
        lock_idx <= grant_idx;
      end
    end
  end

  assign err_o  = err_q;
  assign busy_o = ~&empty;

endmodule

// File: tb/tb_fpnew_opgroup_share_arb.sv
// Self-checking bench for fpnew_opgroup_share_arb.
// Directed scenarios plus randomized traffic against a reference model.
module tb_fpnew_opgroup_share_arb;
  import fpnew_pkg::*;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int NO = 3;
  localparam int MO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst, flush;
  logic [NR-1:0]                 req_valid, req_ready;
  logic [NR-1:0][NO-1:0][W-1:0]  req_operands;
  operation_e [NR-1:0]           req_op;
  logic [NR-1:0]                 req_op_mod;
  fp_format_e [NR-1:0]           req_fmt;
  roundmode_e [NR-1:0]           req_rnd;
  logic                          unit_valid, unit_ready;
  logic [NO-1:0][W-1:0]          unit_operands;
  operation_e                    unit_op;
  logic                          unit_op_mod;
  fp_format_e                    unit_fmt;
  roundmode_e                    unit_rnd;
  logic [1:0]                    unit_tag_out, unit_tag_in;
  logic                          unit_flush;
  logic                          out_valid, out_ready;
  logic [W-1:0]                  unit_result;
  status_t                       unit_status;
  logic [NR-1:0]                 rsp_valid, rsp_ready;
  logic [W-1:0]                  rsp_result;
  status_t                       rsp_status;
  logic                          err, busy;

  fpnew_opgroup_share_arb #(
    .NumReq(NR), .Width(W), .NumOperands(NO), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_operands_i(req_operands), .req_op_i(req_op),
    .req_op_mod_i(req_op_mod), .req_fmt_i(req_fmt),
    .req_rnd_mode_i(req_rnd),
    .unit_valid_o(unit_valid), .unit_ready_i(unit_ready),
    .unit_operands_o(unit_operands), .unit_op_o(unit_op),
    .unit_op_mod_o(unit_op_mod), .unit_fmt_o(unit_fmt),
    .unit_rnd_mode_o(unit_rnd), .unit_tag_o(unit_tag_out),
    .unit_flush_o(unit_flush),
    .unit_out_valid_i(out_valid), .unit_out_ready_o(out_ready),
    .unit_result_i(unit_result), .unit_status_i(unit_status),
    .unit_tag_i(unit_tag_in),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
    .err_o(err), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ptr = 0, m_lock = 0, m_lock_idx = 0, m_err = 0;
  int m_cnt [NR] = '{default: 0};

  // Expected values for the current inputs
  int         e_g;
  bit         e_found, e_uvalid, e_bad, e_busy;
  logic [3:0] e_req_ready, e_rsp_valid;
  logic       e_uoready;

  task automatic model_eval();
    e_found = 0;
    e_g = 0;
    if (m_lock != 0) begin
      e_found = 1;
      e_g = m_lock_idx;
    end else begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (!e_found && req_valid[j] && m_cnt[j] < MO) begin
          e_found = 1;
          e_g = j;
        end
      end
    end
    e_uvalid = e_found && !flush && !rst;
    e_req_ready = '0;
    if (e_uvalid && unit_ready) e_req_ready[e_g] = 1'b1;
    e_bad = out_valid && (m_cnt[unit_tag_in] == 0);
    e_rsp_valid = '0;
    if (!rst && out_valid && !e_bad) e_rsp_valid[unit_tag_in] = 1'b1;
    e_uoready = rst ? 1'b0 : (e_bad ? 1'b1 : rsp_ready[unit_tag_in]);
    e_busy = 0;
    for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) e_busy = 1;
  endtask

  task automatic model_commit();
    if (rst) begin
      m_ptr = 0; m_lock = 0; m_err = 0;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    end else begin
      if (e_bad) m_err = 1;
      if (flush) begin
        m_lock = 0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      end else begin
        if (e_uvalid && unit_ready) begin
          m_cnt[e_g]++;
          m_ptr = (e_g + 1) % NR;
          m_lock = 0;
        end else if (e_uvalid) begin
          m_lock = 1;
          m_lock_idx = e_g;
        end
        if (e_rsp_valid != 0 && rsp_ready[unit_tag_in])
          m_cnt[unit_tag_in]--;
      end
    end
  endtask

  task automatic cycle();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    flush = 0; req_valid = '0; unit_ready = 0;
    out_valid = 0; unit_tag_in = '0; rsp_ready = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NR; i++) begin
      for (int o = 0; o < NO; o++) req_operands[i][o] = $urandom;
      req_op[i]  = operation_e'($urandom_range(0, 14));
      req_fmt[i] = fp_format_e'($urandom_range(0, 4));
      req_rnd[i] = roundmode_e'($urandom_range(0, 4));
    end
    req_op_mod  = 4'($urandom);
    unit_result = $urandom;
    unit_status = status_t'($urandom_range(0, 31));
  endtask

  task automatic test_reset();
    idle();
    rst = 1; req_valid = 4'hF; unit_ready = 1;
    out_valid = 1; rsp_ready = 4'hF; unit_tag_in = 2'd1;
    #1;
    checks++;
    if (unit_valid !== 1'b0 || req_ready !== 4'h0) begin
      errors++;
      $display("FAIL reset_issue got v=%b r=%b exp 0", unit_valid, req_ready);
    end
    checks++;
    if (rsp_valid !== 4'h0 || out_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp got v=%b r=%b exp 0", rsp_valid, out_ready);
    end
    cycle();
    cycle();
    rst = 0;
    idle();
    #1;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got err=%b busy=%b exp 0", err, busy);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_tag;
    req_valid = 4'hF; unit_ready = 1; rsp_ready = 4'hF;
    for (int c = 0; c < 6; c++) begin
      exp_tag = 2'(c % NR);
      #1;
      model_eval();
      checks++;
      if (unit_valid !== 1'b1 || unit_tag_out !== exp_tag
          || req_ready !== (4'b1 << exp_tag)) begin
        errors++;
        $display("FAIL fair_grant c=%0d got v=%b tag=%0d r=%b exp tag=%0d",
                 c, unit_valid, unit_tag_out, req_ready, exp_tag);
      end
      cycle();
      out_valid = 1;
      unit_tag_in = exp_tag;
    end
    req_valid = '0;
    cycle();
    idle();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL fair_drain got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [NO-1:0][W-1:0] ops2;
    do_reset();
    rand_payload();
    ops2 = req_operands[2];
    req_valid = 4'b0100;
    #1;
    checks++;
    if (unit_valid !== 1'b1 || unit_tag_out !== 2'd2) begin
      errors++;
      $display("FAIL bp_first got v=%b tag=%0d exp tag 2", unit_valid, unit_tag_out);
    end
    cycle();
    req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (unit_valid !== 1'b1 || unit_tag_out !== 2'd2
          || unit_operands !== ops2) begin
        errors++;
        $display("FAIL bp_hold c=%0d got v=%b tag=%0d exp tag 2 stable",
                 c, unit_valid, unit_tag_out);
      end
      cycle();
    end
    unit_ready = 1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_accept got %b exp 0100", req_ready);
    end
    cycle();
    req_valid = 4'hF;
    #1;
    checks++;
    if (unit_tag_out !== 2'd3) begin
      errors++;
      $display("FAIL bp_rrptr got %0d exp 3", unit_tag_out);
    end
    idle();
  endtask

  task automatic test_credit();
    do_reset();
    req_valid = 4'b0010; unit_ready = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
        errors++;
        $display("FAIL credit_issue c=%0d got %b exp 0010", c, req_ready);
      end
      cycle();
    end
    #1;
    checks++;
    if (req_ready !== 4'b0000 || unit_valid !== 1'b0) begin
      errors++;
      $display("FAIL credit_block got r=%b v=%b exp 0", req_ready, unit_valid);
    end
    out_valid = 1; unit_tag_in = 2'd1; rsp_ready = 4'b0010;
    #1;
    checks++;
    if (out_ready !== 1'b1 || rsp_valid !== 4'b0010 || req_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL credit_rsp got or=%b rv=%b rr=%b exp 1 0010 0",
               out_ready, rsp_valid, req_ready);
    end
    cycle();
    out_valid = 0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL credit_resume got %b exp 0010", req_ready);
    end
    cycle();
    idle();
  endtask

  task automatic test_routing();
    do_reset();
    req_valid = 4'b1000; unit_ready = 1;
    cycle();
    idle();
    out_valid = 1; unit_tag_in = 2'd3; rsp_ready = 4'b0000;
    #1;
    checks++;
    if (rsp_valid !== 4'b1000 || out_ready !== 1'b0) begin
      errors++;
      $display("FAIL route_stall got rv=%b or=%b exp 1000 0", rsp_valid, out_ready);
    end
    cycle();
    rsp_ready = 4'b1000;
    #1;
    checks++;
    if (busy !== 1'b1 || out_ready !== 1'b1) begin
      errors++;
      $display("FAIL route_accept got busy=%b or=%b exp 1 1", busy, out_ready);
    end
    cycle();
    idle();
    #1;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL route_done got busy=%b err=%b exp 0 0", busy, err);
    end
  endtask

  task automatic test_error();
    do_reset();
    out_valid = 1; unit_tag_in = 2'd2; rsp_ready = 4'b0000;
    #1;
    checks++;
    if (out_ready !== 1'b1 || rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL err_drop got or=%b rv=%b exp 1 0000", out_ready, rsp_valid);
    end
    cycle();
    idle();
    repeat (3) cycle();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b exp 1", err);
    end
    do_reset();
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b exp 0", err);
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    req_valid = 4'b0111; unit_ready = 1;
    repeat (3) cycle();
    req_valid = '0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre got busy=%b exp 1", busy);
    end
    flush = 1; req_valid = 4'hF;
    #1;
    checks++;
    if (unit_flush !== 1'b1 || unit_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_pulse got uf=%b v=%b exp 1 0", unit_flush, unit_valid);
    end
    cycle();
    flush = 0; req_valid = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || unit_flush !== 1'b0) begin
      errors++;
      $display("FAIL flush_post got busy=%b uf=%b exp 0 0", busy, unit_flush);
    end
    rst = 1; req_valid = 4'hF; unit_ready = 1;
    out_valid = 1; unit_tag_in = 2'd0; rsp_ready = 4'hF;
    #1;
    checks++;
    if (unit_valid !== 1'b0 || req_ready !== 4'h0
        || rsp_valid !== 4'h0 || out_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_outputs got v=%b r=%b rv=%b or=%b exp 0",
               unit_valid, req_ready, rsp_valid, out_ready);
    end
    cycle();
    rst = 0; out_valid = 0;
    #1;
    checks++;
    if (unit_valid !== 1'b1 || unit_tag_out !== 2'd0) begin
      errors++;
      $display("FAIL rst_rrptr got v=%b tag=%0d exp 1 0", unit_valid, unit_tag_out);
    end
    cycle();
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int live [$];
      rand_payload();
      req_valid  = 4'($urandom);
      unit_ready = ($urandom % 4) != 0;
      out_valid  = ($urandom % 3) == 0;
      rsp_ready  = 4'($urandom);
      flush      = ($urandom % 25) == 0;
      for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) live.push_back(i);
      if (live.size() != 0 && ($urandom % 10) != 0)
        unit_tag_in = 2'(live[$urandom_range(0, live.size() - 1)]);
      else
        unit_tag_in = 2'($urandom);
      #1;
      model_eval();
      checks++;
      if (unit_valid !== e_uvalid || req_ready !== e_req_ready
          || (e_uvalid && unit_tag_out !== 2'(e_g))) begin
        errors++;
        $display("FAIL rnd_issue c=%0d got v=%b r=%b tag=%0d exp v=%b r=%b tag=%0d",
                 c, unit_valid, req_ready, unit_tag_out, e_uvalid, e_req_ready, e_g);
      end
      checks++;
      if (e_uvalid && (unit_operands !== req_operands[e_g]
          || unit_op !== req_op[e_g] || unit_fmt !== req_fmt[e_g]
          || unit_rnd !== req_rnd[e_g] || unit_op_mod !== req_op_mod[e_g])) begin
        errors++;
        $display("FAIL rnd_payload c=%0d got op=%0d exp op=%0d",
                 c, unit_op, req_op[e_g]);
      end
      checks++;
      if (rsp_valid !== e_rsp_valid || out_ready !== e_uoready
          || rsp_result !== unit_result || rsp_status !== unit_status) begin
        errors++;
        $display("FAIL rnd_rsp c=%0d got rv=%b or=%b exp rv=%b or=%b",
                 c, rsp_valid, out_ready, e_rsp_valid, e_uoready);
      end
      checks++;
      if (err !== 1'(m_err) || busy !== e_busy || unit_flush !== flush) begin
        errors++;
        $display("FAIL rnd_status c=%0d got err=%b busy=%b exp err=%0d busy=%b",
                 c, err, busy, m_err, e_busy);
      end
      cycle();
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    rand_payload();
    test_reset();
    test_fairness();
    test_back_to_back();
    test_credit();
    test_routing();
    test_error();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
